// File: rtl/vc_pkg.sv
// Shared types and width helpers for the line arbiter and its pickers.
// State encodings plus constant functions used to size index ports.
package vc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HOLD   = 2'd2
    } arb_state_e;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Byte-offset bits inside a cache line.
    function automatic int lb_of(input int len);
        return (len > 1) ? $clog2(len) : 0;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner select: lowest index, or first at/after a pointer.
// Produces a one-hot winner, its binary index and a valid flag.
module rr_pick #(
    parameter int N  = 2,
    parameter int CW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] ptr,
    input  logic          mode,
    output logic [N-1:0]  win_oh,
    output logic [CW-1:0] win_idx,
    output logic          win_vld
);

    always_comb begin
        int j;
        j       = 0;
        win_oh  = '0;
        win_idx = '0;
        win_vld = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = mode ? ((int'(ptr) + k) % N) : k;
            if (!win_vld && req[j]) begin
                win_vld    = 1'b1;
                win_oh[j]  = 1'b1;
                win_idx    = j[CW-1:0];
            end
        end
    end

endmodule

// File: rtl/line_arb.sv
// N-channel line fill/evict arbiter in front of the single QSPI line engine.
// Supports fixed/round-robin pick, locked back-to-back transfers and a watchdog.
module line_arb
    import vc_pkg::*;
#(
    parameter int NCH         = 2,
    parameter int PA          = 22,
    parameter int LINE_LENGTH = 4,
    parameter int MODE        = 0,
    parameter int TIMEOUT     = 255
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NCH-1:0]                          ch_req,
    input  logic [NCH-1:0]                          ch_write,
    input  logic [NCH-1:0]                          ch_mem,
    input  logic [NCH-1:0]                          ch_lock,
    input  logic [NCH*(PA-lb_of(LINE_LENGTH))-1:0]  ch_tag,
    output logic [NCH-1:0]                          ch_gnt,
    output logic [NCH-1:0]                          ch_wstrobe,
    output logic [NCH-1:0]                          ch_rstrobe,
    output logic [NCH-1:0]                          ch_done,
    output logic [NCH-1:0]                          ch_err,
    output logic                                    q_req,
    output logic                                    q_write,
    output logic                                    q_mem,
    output logic [PA-lb_of(LINE_LENGTH)-1:0]        q_paddr,
    output logic [clog2_min1(NCH)-1:0]              q_ch,
    input  logic                                    q_wstrobe,
    input  logic                                    q_rstrobe,
    input  logic                                    q_done,
    output logic                                    busy
);

    localparam int LB = lb_of(LINE_LENGTH);
    localparam int TW = PA - LB;
    localparam int CW = clog2_min1(NCH);
    localparam int WW = clog2_min1(TIMEOUT + 1);
    localparam bit WD_EN = (TIMEOUT > 0);
    localparam logic [WW-1:0] WD_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_e     state_q, state_d;
    logic [NCH-1:0] gnt_q, gnt_d;
    logic           q_req_q, q_req_d;
    logic [CW-1:0]  q_ch_q, q_ch_d;
    logic [CW-1:0]  rr_q, rr_d;
    logic [WW-1:0]  wd_q, wd_d;

    logic [NCH-1:0] win_oh;
    logic [CW-1:0]  win_idx;
    logic           win_vld;
    logic [CW-1:0]  rr_nxt;
    logic [TW-1:0]  tag_sel;
    logic           wr_sel;
    logic           mem_sel;
    logic           active;
    logic           wd_hit;
    logic           xfer_end;

    rr_pick #(
        .N  (NCH),
        .CW (CW)
    ) u_pick (
        .req     (ch_req),
        .ptr     (rr_q),
        .mode    (MODE == 1),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .win_vld (win_vld)
    );

    // Grant is one-hot, so an OR-select doubles as the idle gate.
    always_comb begin
        tag_sel = '0;
        wr_sel  = 1'b0;
        mem_sel = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt_q[i]) begin
                tag_sel = ch_tag[i*TW +: TW];
                wr_sel  = ch_write[i];
                mem_sel = ch_mem[i];
            end
        end
    end

    assign active   = (state_q == ST_ACTIVE);
    assign wd_hit   = WD_EN && active && (wd_q == WD_LAST);
    assign xfer_end = active && (q_done || wd_hit);

    always_comb begin
        if (q_ch_q == CW'(NCH - 1)) begin
            rr_nxt = '0;
        end else begin
            rr_nxt = q_ch_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        q_req_d = q_req_q;
        q_ch_d  = q_ch_q;
        rr_d    = rr_q;
        wd_d    = wd_q;
        unique case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d = ST_ACTIVE;
                    gnt_d   = win_oh;
                    q_ch_d  = win_idx;
                    q_req_d = 1'b1;
                    wd_d    = '0;
                end
            end
            ST_ACTIVE: begin
                wd_d = wd_q + 1'b1;
                if (q_done || wd_hit) begin
                    q_req_d = 1'b0;
                    if (MODE == 1) begin
                        rr_d = rr_nxt;
                    end
                    // A watchdog abort never honours the lock.
                    if (q_done && |(ch_lock & gnt_q)) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            ST_HOLD: begin
                if (|(ch_req & gnt_q)) begin
                    state_d = ST_ACTIVE;
                    q_req_d = 1'b1;
                    wd_d    = '0;
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                q_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            q_req_q <= 1'b0;
            q_ch_q  <= '0;
            rr_q    <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            q_req_q <= q_req_d;
            q_ch_q  <= q_ch_d;
            rr_q    <= rr_d;
            wd_q    <= wd_d;
        end
    end

    assign ch_gnt     = gnt_q;
    assign ch_wstrobe = gnt_q & {NCH{q_wstrobe}};
    assign ch_rstrobe = gnt_q & {NCH{q_rstrobe}};
    assign ch_done    = gnt_q & {NCH{xfer_end}};
    assign ch_err     = gnt_q & {NCH{wd_hit && !q_done}};
    assign q_req      = q_req_q;
    assign q_write    = wr_sel;
    assign q_mem      = mem_sel;
    assign q_paddr    = tag_sel;
    assign q_ch       = q_ch_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_line_arb.sv
// Directed bench: fixed-priority/lock/watchdog vectors on a 2-channel arbiter,
// then round-robin order and async reset on a 4-channel arbiter.
module tb_line_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    localparam logic [19:0] TAG0 = 20'h12345;
    localparam logic [19:0] TAG1 = 20'h0ABCD;

    // Instance A: NCH=2, fixed priority, TIMEOUT=10
    logic        rst_a;
    logic [1:0]  a_req, a_wr, a_mem, a_lock;
    logic [39:0] a_tag;
    logic [1:0]  a_gnt, a_ws, a_rs, a_done, a_err;
    logic        a_qreq, a_qw, a_qm, a_busy;
    logic [19:0] a_paddr;
    logic [0:0]  a_qch;
    logic        a_qws, a_qrs, a_qdone;

    line_arb #(
        .NCH(2), .PA(22), .LINE_LENGTH(4), .MODE(0), .TIMEOUT(10)
    ) dut_a (
        .clk(clk), .reset(rst_a),
        .ch_req(a_req), .ch_write(a_wr), .ch_mem(a_mem),
        .ch_lock(a_lock), .ch_tag(a_tag),
        .ch_gnt(a_gnt), .ch_wstrobe(a_ws), .ch_rstrobe(a_rs),
        .ch_done(a_done), .ch_err(a_err),
        .q_req(a_qreq), .q_write(a_qw), .q_mem(a_qm),
        .q_paddr(a_paddr), .q_ch(a_qch),
        .q_wstrobe(a_qws), .q_rstrobe(a_qrs), .q_done(a_qdone),
        .busy(a_busy)
    );

    // Instance B: NCH=4, round robin, TIMEOUT=255
    logic        rst_b;
    logic [3:0]  b_req, b_wr, b_mem, b_lock;
    logic [79:0] b_tag;
    logic [3:0]  b_gnt, b_ws, b_rs, b_done, b_err;
    logic        b_qreq, b_qw, b_qm, b_busy;
    logic [19:0] b_paddr;
    logic [1:0]  b_qch;
    logic        b_qws, b_qrs, b_qdone;

    line_arb #(
        .NCH(4), .PA(22), .LINE_LENGTH(4), .MODE(1), .TIMEOUT(255)
    ) dut_b (
        .clk(clk), .reset(rst_b),
        .ch_req(b_req), .ch_write(b_wr), .ch_mem(b_mem),
        .ch_lock(b_lock), .ch_tag(b_tag),
        .ch_gnt(b_gnt), .ch_wstrobe(b_ws), .ch_rstrobe(b_rs),
        .ch_done(b_done), .ch_err(b_err),
        .q_req(b_qreq), .q_write(b_qw), .q_mem(b_qm),
        .q_paddr(b_paddr), .q_ch(b_qch),
        .q_wstrobe(b_qws), .q_rstrobe(b_qrs), .q_done(b_qdone),
        .busy(b_busy)
    );

    typedef struct {
        logic [1:0] req, wr, lk;
        logic       ws, rs, dn;
        logic [1:0] g;
        logic       qr;
        logic [1:0] d, er, ews, ers;
        logic       qw;
    } vec_t;

    vec_t v[$];

    function automatic vec_t mk(
        input logic [1:0] req, wr, lk,
        input logic ws, rs, dn,
        input logic [1:0] g, input logic qr,
        input logic [1:0] d, er, ews, ers,
        input logic qw
    );
        vec_t r;
        r.req = req; r.wr = wr; r.lk = lk;
        r.ws = ws; r.rs = rs; r.dn = dn;
        r.g = g; r.qr = qr; r.d = d; r.er = er;
        r.ews = ews; r.ers = ers; r.qw = qw;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    logic [3:0]  order [6];
    logic [19:0] paddr_at [6];
    logic [19:0] exp_tag;
    logic [19:0] e_paddr;
    logic        e_qch;
    logic        a_qch_m;
    int          seen;
    int          act;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        a_req = '0; a_wr = '0; a_mem = 2'b01; a_lock = '0;
        a_tag = {TAG1, TAG0};
        a_qws = 1'b0; a_qrs = 1'b0; a_qdone = 1'b0;
        b_req = '0; b_wr = '0; b_mem = '0; b_lock = '0;
        b_tag = {20'hD3333, 20'hC2222, 20'hB1111, 20'hA0000};
        b_qws = 1'b0; b_qrs = 1'b0; b_qdone = 1'b0;

        // req wr lk ws rs dn | gnt qreq done err wstb rstb qwrite
        v.push_back(mk(2'b11, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        v.push_back(mk(2'b11, 2'b00, 2'b00, 1, 0, 0, 2'b01, 1, 2'b00, 2'b00, 2'b01, 2'b00, 0));
        v.push_back(mk(2'b11, 2'b00, 2'b00, 0, 1, 0, 2'b01, 1, 2'b00, 2'b00, 2'b00, 2'b01, 0));
        v.push_back(mk(2'b11, 2'b00, 2'b00, 1, 1, 0, 2'b01, 1, 2'b00, 2'b00, 2'b01, 2'b01, 0));
        v.push_back(mk(2'b10, 2'b00, 2'b00, 0, 0, 1, 2'b01, 1, 2'b01, 2'b00, 2'b00, 2'b00, 0));
        v.push_back(mk(2'b10, 2'b10, 2'b10, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        v.push_back(mk(2'b11, 2'b10, 2'b10, 1, 1, 0, 2'b10, 1, 2'b00, 2'b00, 2'b10, 2'b10, 1));
        v.push_back(mk(2'b11, 2'b10, 2'b10, 0, 0, 1, 2'b10, 1, 2'b10, 2'b00, 2'b00, 2'b00, 1));
        v.push_back(mk(2'b11, 2'b00, 2'b00, 0, 0, 0, 2'b10, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        v.push_back(mk(2'b11, 2'b00, 2'b00, 0, 1, 0, 2'b10, 1, 2'b00, 2'b00, 2'b00, 2'b10, 0));
        v.push_back(mk(2'b11, 2'b00, 2'b00, 0, 0, 1, 2'b10, 1, 2'b10, 2'b00, 2'b00, 2'b00, 0));
        v.push_back(mk(2'b11, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        for (int i = 0; i < 9; i++)
            v.push_back(mk(2'b01, 2'b00, 2'b01, 0, 0, 0, 2'b01, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        v.push_back(mk(2'b01, 2'b00, 2'b01, 0, 0, 0, 2'b01, 1, 2'b01, 2'b01, 2'b00, 2'b00, 0));
        v.push_back(mk(2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        v.push_back(mk(2'b01, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        for (int i = 0; i < 9; i++)
            v.push_back(mk(2'b01, 2'b00, 2'b00, 0, 0, 0, 2'b01, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        v.push_back(mk(2'b01, 2'b00, 2'b00, 0, 0, 1, 2'b01, 1, 2'b01, 2'b00, 2'b00, 2'b00, 0));
        v.push_back(mk(2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));

        repeat (2) @(negedge clk);
        rst_a = 1'b0;

        for (int i = 0; i < v.size(); i++) begin
            @(negedge clk);
            a_req = v[i].req; a_wr = v[i].wr; a_lock = v[i].lk;
            a_qws = v[i].ws; a_qrs = v[i].rs; a_qdone = v[i].dn;
            #1;
            e_paddr = (v[i].g == 2'b01) ? TAG0 :
                      (v[i].g == 2'b10) ? TAG1 : 20'h0;
            e_qch   = v[i].g[1];
            // q_ch is only meaningful while a grant is held
            a_qch_m = (v[i].g != 2'b00) ? a_qch[0] : 1'b0;
            check($sformatf("vec%0d", i),
                  {29'h0, a_gnt, a_qreq, a_qch_m, a_done, a_err,
                   a_ws, a_rs, a_qw, a_qm, a_busy, a_paddr},
                  {29'h0, v[i].g, v[i].qr, e_qch, v[i].d, v[i].er,
                   v[i].ews, v[i].ers, v[i].qw, v[i].g[0],
                   (v[i].g != 2'b00), e_paddr});
        end
        @(negedge clk);
        a_req = '0; a_qdone = 1'b0;

        // Round robin: all four requesting, q_done on 5th active cycle
        rst_b = 1'b0;
        b_req = 4'hF;
        seen = 0;
        act  = 0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (b_gnt != 4'h0) begin
                if (act == 0) begin
                    if (seen < 6) begin
                        order[seen]    = b_gnt;
                        paddr_at[seen] = b_paddr;
                    end
                    seen++;
                end
                act++;
            end else begin
                act = 0;
            end
            b_qdone = (act == 5);
            if (seen == 6 && act == 3) break;
        end
        check("rr_grants_seen", 64'(seen), 64'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("rr_order%0d", i), 64'(order[i]),
                  64'(4'b0001 << (i % 4)));
            case (i % 4)
                0: exp_tag = 20'hA0000;
                1: exp_tag = 20'hB1111;
                2: exp_tag = 20'hC2222;
                default: exp_tag = 20'hD3333;
            endcase
            check($sformatf("rr_paddr%0d", i), 64'(paddr_at[i]), 64'(exp_tag));
        end

        // Async reset 3 cycles into ch1's transfer
        b_qdone = 1'b0;
        #2 rst_b = 1'b1;
        #1;
        check("rst_async_gnt", 64'(b_gnt), 64'h0);
        check("rst_async_qreq", 64'(b_qreq), 64'h0);
        check("rst_async_busy", 64'(b_busy), 64'h0);
        check("rst_async_done", 64'(b_done), 64'h0);
        repeat (2) begin
            @(negedge clk);
            check("rst_hold", 64'({b_gnt, b_done, b_qreq}), 64'h0);
        end
        rst_b = 1'b0;
        #1;
        check("rst_rel_gnt", 64'(b_gnt), 64'h0);
        @(negedge clk);
        #1;
        check("regrant_gnt", 64'(b_gnt), 64'h1);
        check("regrant_qreq", 64'(b_qreq), 64'h1);
        check("regrant_qch", 64'(b_qch), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
